// File: rtl/seq_mod_arbiter_pkg.sv
// Shared widths and FSM encoding for the arbiter that multiplexes requesters
// onto one shared mod-(2^255-19) reducer.
package seq_mod_arbiter_pkg;

   localparam int B     = 256;
   localparam int B2    = 512;
   localparam int CNT_W = 11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/seq_mod_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. NREQ is a power of two so the index wraps naturally.
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  grant_o,
   output logic [IDX_W-1:0] index_o
);

   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      grant_o = '0;
      index_o = '0;
      cand    = '0;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr_i + IDX_W'(k);
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            index_o       = cand;
         end
      end
   end

endmodule

// File: rtl/seq_mod_arbiter.sv
// Arbitrates NREQ requesters onto a single external reducer, one operation in
// flight, with a cycle-bounded wait and a timeout error response.
//
// state   | meaning
// S_IDLE  | sample req, latch winner operand, pulse ack and red_start
// S_ISSUE | red_start visible, clear wait counter
// S_WAIT  | wait for first red_done or timeout
// S_RESP  | rsp_valid visible, advance round-robin pointer
module seq_mod_arbiter
   import seq_mod_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*B2-1:0]   x_in,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [B-1:0]         rsp_mod,
   output logic                 rsp_err,
   output logic                 red_start,
   output logic [B2-1:0]        red_x,
   input  logic [B-1:0]         red_mod,
   input  logic                 red_done
);

   localparam int IDX_W = $clog2(NREQ);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [IDX_W-1:0]  id_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [NREQ-1:0]   ack_q;
   logic [NREQ-1:0]   rsp_valid_q;
   logic [B-1:0]      rsp_mod_q;
   logic              rsp_err_q;
   logic              red_start_q;
   logic [B2-1:0]     red_x_q;

   logic [NREQ-1:0]   win_grant;
   logic [IDX_W-1:0]  win_idx;
   logic [B2-1:0]     win_x_d;
   logic [NREQ-1:0]   id_oh;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (win_grant),
      .index_o (win_idx)
   );

   always_comb begin
      win_x_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == IDX_W'(i)) win_x_d = x_in[i*B2 +: B2];
      end
   end

   assign id_oh = {{(NREQ-1){1'b0}}, 1'b1} << id_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         ack_q       <= '0;
         rsp_valid_q <= '0;
         rsp_mod_q   <= '0;
         rsp_err_q   <= 1'b0;
         red_start_q <= 1'b0;
         red_x_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|req) begin
                  id_q        <= win_idx;
                  red_x_q     <= win_x_d;
                  ack_q       <= win_grant;
                  red_start_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               ack_q       <= '0;
               red_start_q <= 1'b0;
               cnt_q       <= '0;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               // red_done wins over a timeout landing on the same cycle
               if (red_done) begin
                  rsp_mod_q   <= red_mod;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= id_oh;
                  state_q     <= S_RESP;
               end else if (cnt_q == TO_LAST) begin
                  rsp_mod_q   <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= id_oh;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RESP: begin
               rsp_valid_q <= '0;
               ptr_q       <= id_q + IDX_W'(1);
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ack       = ack_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_mod   = rsp_mod_q;
   assign rsp_err   = rsp_err_q;
   assign red_start = red_start_q;
   assign red_x     = red_x_q;

endmodule

// File: tb/tb_seq_mod_arbiter.sv
// Directed bench for seq_mod_arbiter with a behavioural mod-(2^255-19) reducer
// of fixed latency that can be disabled to exercise the timeout path.
module tb_seq_mod_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;
   localparam int LAT     = 5;
   localparam logic [511:0] Q = (512'd1 << 255) - 512'd19;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*512-1:0]  x_in = '0;
   logic [NREQ-1:0]      ack;
   logic [NREQ-1:0]      rsp_valid;
   logic [255:0]         rsp_mod;
   logic                 rsp_err;
   logic                 red_start;
   logic [511:0]         red_x;
   logic [255:0]         red_mod;
   logic                 red_done;

   logic                 model_en = 1'b1;
   logic                 model_done = 1'b0;
   logic [255:0]         model_mod = '0;
   logic                 busy = 1'b0;
   int                   lat_cnt = 0;
   logic                 force_done = 1'b0;
   logic [255:0]         force_mod = '0;

   int n_pass  = 0;
   int n_total = 0;
   int n_start = 0;

   seq_mod_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .x_in      (x_in),
      .ack       (ack),
      .rsp_valid (rsp_valid),
      .rsp_mod   (rsp_mod),
      .rsp_err   (rsp_err),
      .red_start (red_start),
      .red_x     (red_x),
      .red_mod   (red_mod),
      .red_done  (red_done)
   );

   always #5 clk = ~clk;

   assign red_done = model_done | force_done;
   assign red_mod  = force_done ? force_mod : model_mod;

   always @(posedge clk) begin
      model_done <= 1'b0;
      if (rst) begin
         busy    <= 1'b0;
         lat_cnt <= 0;
      end else if (busy) begin
         if (lat_cnt == 1) begin
            model_done <= 1'b1;
            busy       <= 1'b0;
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end else if (red_start && model_en) begin
         model_mod <= 256'(red_x % Q);
         lat_cnt   <= LAT;
         busy      <= 1'b1;
      end
   end

   always @(negedge clk) if (red_start === 1'b1) n_start = n_start + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   task automatic wait_ack(input int max, output bit ok, output int cyc);
      ok = 1'b0; cyc = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         cyc = cyc + 1;
         if (ack !== '0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_rsp(input int max, output bit ok, output int cyc);
      ok = 1'b0; cyc = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         cyc = cyc + 1;
         if (rsp_valid !== '0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic set_x(input int i, input logic [511:0] v);
      x_in[i*512 +: 512] = v;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      x_in = {NREQ*16{32'hA5A5_5A5A}};
      req = 4'b1111;
      repeat (3) @(negedge clk);
      n_total++; if (ack !== 4'b0) $display("FAIL reset_ack got %b want 0000", ack); else n_pass++;
      n_total++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); else n_pass++;
      n_total++; if ({rsp_mod, rsp_err, red_start} !== '0) $display("FAIL reset_rsp got mod=%h err=%b start=%b want 0", rsp_mod, rsp_err, red_start); else n_pass++;
      n_total++; if (red_x !== 512'd0) $display("FAIL reset_red_x got %h want 0", red_x); else n_pass++;
      req = '0;
      x_in = '0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single;
      bit ok; int cyc, cyc2;
      set_x(0, 512'd1 << 511);
      req = 4'b0001;
      wait_ack(5, ok, cyc);
      n_total++; if (!ok || ack !== 4'b0001) $display("FAIL single_ack got %b want 0001", ack); else n_pass++;
      n_total++; if (red_start !== 1'b1) $display("FAIL single_start got %b want 1", red_start); else n_pass++;
      req = '0;
      @(negedge clk);
      n_total++; if (ack !== 4'b0) $display("FAIL single_ack_pulse got %b want 0000", ack); else n_pass++;
      wait_rsp(60, ok, cyc2);
      n_total++; if (!ok) $display("FAIL single_rsp_timeout got none want rsp_valid"); else n_pass++;
      n_total++; if (1 + cyc2 != LAT + 2) $display("FAIL single_latency got %0d want %0d", 1 + cyc2, LAT + 2); else n_pass++;
      n_total++; if (rsp_valid !== 4'b0001) $display("FAIL single_valid got %b want 0001", rsp_valid); else n_pass++;
      n_total++; if (rsp_mod !== 256'd722 || rsp_err !== 1'b0) $display("FAIL single_mod got %0d err=%b want 722 err=0", rsp_mod, rsp_err); else n_pass++;
      n_total++; if (red_x !== (512'd1 << 511)) $display("FAIL single_red_x_hold got %h want 2^511", red_x); else n_pass++;
      @(negedge clk);
      n_total++; if (rsp_valid !== 4'b0) $display("FAIL single_valid_pulse got %b want 0000", rsp_valid); else n_pass++;
   endtask

   task automatic test_exact_modulus;
      bit ok; int cyc;
      logic [255:0] exp_mod [2];
      logic [511:0] xv [2];
      xv[0] = Q;        exp_mod[0] = 256'd0;
      xv[1] = Q + 512'd5; exp_mod[1] = 256'd5;
      for (int t = 0; t < 2; t++) begin
         set_x(2, xv[t]);
         req = 4'b0100;
         wait_ack(5, ok, cyc);
         n_total++; if (!ok || ack !== 4'b0100) $display("FAIL exact_ack[%0d] got %b want 0100", t, ack); else n_pass++;
         req = '0;
         wait_rsp(60, ok, cyc);
         n_total++; if (!ok || rsp_valid !== 4'b0100) $display("FAIL exact_valid[%0d] got %b want 0100", t, rsp_valid); else n_pass++;
         n_total++; if (rsp_mod !== exp_mod[t]) $display("FAIL exact_mod[%0d] got %0d want %0d", t, rsp_mod, exp_mod[t]); else n_pass++;
      end
   endtask

   task automatic test_contention;
      bit ok; int cyc;
      logic [3:0] exp_oh;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_x(i, 512'(i + 1));
      n_start = 0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_rsp(60, ok, cyc);
         exp_oh = 4'b0001 << (k % 4);
         n_total++; if (!ok || rsp_valid !== exp_oh) $display("FAIL contention_order[%0d] got %b want %b", k, rsp_valid, exp_oh); else n_pass++;
         n_total++; if (rsp_mod !== 256'(k % 4 + 1)) $display("FAIL contention_mod[%0d] got %0d want %0d", k, rsp_mod, k % 4 + 1); else n_pass++;
         if (k == 4) req = '0;
      end
      repeat (5) @(negedge clk);
      n_total++; if (n_start != 5) $display("FAIL contention_starts got %0d want 5", n_start); else n_pass++;
   endtask

   task automatic test_timeout;
      bit ok; int cyc;
      model_en = 1'b0;
      set_x(3, 512'd42);
      req = 4'b1000;
      wait_ack(5, ok, cyc);
      n_total++; if (!ok || ack !== 4'b1000) $display("FAIL timeout_ack got %b want 1000", ack); else n_pass++;
      req = '0;
      wait_rsp(80, ok, cyc);
      n_total++; if (!ok || cyc != TIMEOUT + 1) $display("FAIL timeout_cycles got %0d want %0d", cyc, TIMEOUT + 1); else n_pass++;
      n_total++; if (rsp_valid !== 4'b1000) $display("FAIL timeout_valid got %b want 1000", rsp_valid); else n_pass++;
      n_total++; if (rsp_err !== 1'b1 || rsp_mod !== 256'd0) $display("FAIL timeout_err got err=%b mod=%0d want err=1 mod=0", rsp_err, rsp_mod); else n_pass++;
      model_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait;
      bit ok; int cyc;
      bit seen;
      set_x(1, 512'd7);
      req = 4'b0010;
      wait_ack(5, ok, cyc);
      req = '0;
      wait_rsp(60, ok, cyc);
      n_total++; if (!ok || rsp_valid !== 4'b0010 || rsp_mod !== 256'd7) $display("FAIL midrst_pre got valid=%b mod=%0d want 0010 7", rsp_valid, rsp_mod); else n_pass++;
      model_en = 1'b0;
      set_x(2, 512'd9);
      req = 4'b0100;
      wait_ack(5, ok, cyc);
      req = '0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++; if ({ack, rsp_valid, rsp_mod, rsp_err, red_start, red_x} !== '0)
         $display("FAIL midrst_async got ack=%b valid=%b mod=%0d err=%b start=%b x=%0h want all 0", ack, rsp_valid, rsp_mod, rsp_err, red_start, red_x);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      force_mod  = 256'd123;
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid !== '0 || ack !== '0 || red_start !== 1'b0) seen = 1'b1;
      end
      n_total++; if (seen) $display("FAIL midrst_late_done got activity=1 want 0"); else n_pass++;
      n_total++; if (rsp_mod !== 256'd0) $display("FAIL midrst_mod got %0d want 0", rsp_mod); else n_pass++;
      model_en = 1'b1;
      for (int i = 0; i < NREQ; i++) set_x(i, 512'(i + 1));
      req = 4'b1111;
      wait_ack(5, ok, cyc);
      n_total++; if (!ok || ack !== 4'b0001) $display("FAIL midrst_ptr got %b want 0001", ack); else n_pass++;
      req = '0;
      wait_rsp(60, ok, cyc);
      n_total++; if (!ok || rsp_valid !== 4'b0001 || rsp_mod !== 256'd1) $display("FAIL midrst_after got valid=%b mod=%0d want 0001 1", rsp_valid, rsp_mod); else n_pass++;
   endtask

   task automatic test_stray_done;
      bit ok; int cyc;
      bit seen;
      repeat (2) @(negedge clk);
      force_mod  = 256'd55;
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid !== '0 || ack !== '0 || red_start !== 1'b0) seen = 1'b1;
      end
      n_total++; if (seen) $display("FAIL stray_activity got 1 want 0"); else n_pass++;
      n_total++; if (rsp_mod !== 256'd1) $display("FAIL stray_mod got %0d want 1", rsp_mod); else n_pass++;
      set_x(2, 512'd11);
      req = 4'b0100;
      wait_ack(5, ok, cyc);
      n_total++; if (!ok || cyc != 1 || ack !== 4'b0100) $display("FAIL stray_idle got ack=%b after %0d want 0100 after 1", ack, cyc); else n_pass++;
      req = '0;
      wait_rsp(60, ok, cyc);
      n_total++; if (!ok || rsp_valid !== 4'b0100 || rsp_mod !== 256'd11) $display("FAIL stray_after got valid=%b mod=%0d want 0100 11", rsp_valid, rsp_mod); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_exact_modulus();
      test_contention();
      test_timeout();
      test_reset_mid_wait();
      test_stray_done();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
